// File: rtl/stream_demux1_2.sv
// stream_demux1_2: steers a select-tagged valid/ready stream into two independently
// back-pressured channels (A for sel 0, B for sel 1), each buffered by its own FIFO.
module stream_demux1_2 #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] a_data,
   output logic             a_valid,
   input  logic             a_ready,
   output logic [WIDTH-1:0] b_data,
   output logic             b_valid,
   input  logic             b_ready,
   output logic [LW-1:0]    a_level,
   output logic [LW-1:0]    b_level
);
   logic [1:0]            w_full;
   logic [1:0]            w_rdy;
   logic [1:0][WIDTH-1:0] w_data;
   logic [1:0][LW-1:0]    w_lvl;
   assign w_rdy    = {b_ready, a_ready};
   // in_ready looks only at the selected FIFO's registered fullness, never at the consumers
   assign in_ready = !w_full[in_sel];
   assign a_data   = w_data[0];
   assign b_data   = w_data[1];
   assign a_level  = w_lvl[0];
   assign b_level  = w_lvl[1];
   assign a_valid  = w_lvl[0] != '0;
   assign b_valid  = w_lvl[1] != '0;
   genvar c;
   for (c = 0; c < 2; c++) begin : g_ch
      logic [WIDTH-1:0] r_mem [DEPTH];
      logic [AW-1:0]    r_wp;
      logic [AW-1:0]    r_rp;
      logic [LW-1:0]    r_lvl;
      logic             w_push;
      logic             w_pop;
      logic             w_hit;
      assign w_hit     = (c == 1) ? in_sel : !in_sel;
      assign w_full[c] = r_lvl == LW'(DEPTH);
      assign w_push    = in_valid && w_hit && !w_full[c];
      assign w_pop     = (r_lvl != '0) && w_rdy[c];
      assign w_data[c] = r_mem[r_rp];
      assign w_lvl[c]  = r_lvl;
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_lvl <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         end else begin
            if (w_push) begin
               r_mem[r_wp] <= in_data;
               r_wp        <= r_wp + 1'b1;
            end
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_lvl <= r_lvl + LW'(w_push) - LW'(w_pop);
         end
      end
   end
endmodule

// File: tb/tb_stream_demux1_2.sv
// tb_stream_demux1_2: queue-based channel model checked every cycle, plus directed
// literal expectations and a random traffic phase.
module tb_stream_demux1_2;
   localparam int WIDTH = 8;
   localparam int DEPTH = 2;
   localparam int LW = $clog2(DEPTH) + 1;

   logic             clk = 0;
   logic             rst_n = 0;
   logic [WIDTH-1:0] in_data = 0;
   logic             in_sel = 0;
   logic             in_valid = 0;
   logic             in_ready;
   logic [WIDTH-1:0] a_data, b_data;
   logic             a_valid, b_valid;
   logic             a_ready = 0, b_ready = 0;
   logic [LW-1:0]    a_level, b_level;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 0;
   logic [WIDTH-1:0] qa[$];
   logic [WIDTH-1:0] qb[$];

   stream_demux1_2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
      .in_valid(in_valid), .in_ready(in_ready), .a_data(a_data),
      .a_valid(a_valid), .a_ready(a_ready), .b_data(b_data),
      .b_valid(b_valid), .b_ready(b_ready), .a_level(a_level), .b_level(b_level)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // channel model: each channel is a bounded queue; a full channel refuses pushes
   always @(posedge clk) begin
      bit pa, pb, push;
      if (!rst_n) begin
         qa.delete();
         qb.delete();
         chk_en = 1;
      end else begin
         pa = a_ready && qa.size() > 0;
         pb = b_ready && qb.size() > 0;
         push = in_valid && ((in_sel ? qb.size() : qa.size()) < DEPTH);
         if (pa) void'(qa.pop_front());
         if (pb) void'(qb.pop_front());
         if (push && !in_sel) qa.push_back(in_data);
         if (push && in_sel) qb.push_back(in_data);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_a_valid", 32'(a_valid), 32'(qa.size() != 0));
         check("m_b_valid", 32'(b_valid), 32'(qb.size() != 0));
         check("m_a_level", 32'(a_level), 32'(qa.size()));
         check("m_b_level", 32'(b_level), 32'(qb.size()));
         check("m_in_ready", 32'(in_ready), 32'((in_sel ? qb.size() : qa.size()) < DEPTH));
         if (qa.size() != 0) check("m_a_data", 32'(a_data), 32'(qa[0]));
         if (qb.size() != 0) check("m_b_data", 32'(b_data), 32'(qb[0]));
      end
   end

   task automatic send(input logic [WIDTH-1:0] d, input logic s);
      in_data = d;
      in_sel = s;
      in_valid = 1;
      step();
      in_valid = 0;
   endtask

   initial begin
      step();
      step();
      rst_n = 1;
      #1;
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_a_valid", 32'(a_valid), 0);
      check("rst_b_valid", 32'(b_valid), 0);
      check("rst_a_level", 32'(a_level), 0);
      check("rst_b_level", 32'(b_level), 0);
      check("rst_a_data", 32'(a_data), 0);
      check("rst_b_data", 32'(b_data), 0);
      send(8'h11, 0);
      check("route_a_valid", 32'(a_valid), 1);
      check("route_a_data", 32'(a_data), 32'h11);
      send(8'h22, 1);
      check("route_b_valid", 32'(b_valid), 1);
      check("route_b_data", 32'(b_data), 32'h22);
      a_ready = 1;
      b_ready = 1;
      step();
      check("route_drained", 32'({a_level, b_level}), 0);
      a_ready = 0;
      b_ready = 0;
      send(8'h01, 0);
      send(8'h02, 0);
      in_data = 8'h03;
      in_sel = 0;
      in_valid = 1;
      #1;
      check("fill_in_ready", 32'(in_ready), 0);
      check("fill_a_level", 32'(a_level), 2);
      step();
      check("fill_refused_level", 32'(a_level), 2);
      in_data = 8'h04;
      in_sel = 1;
      #1;
      check("fill_b_in_ready", 32'(in_ready), 1);
      step();
      in_valid = 0;
      check("fill_b_data", 32'(b_data), 32'h04);
      check("fill_b_level", 32'(b_level), 1);
      a_ready = 1;
      #1;
      check("drain_head0", 32'(a_data), 32'h01);
      step();
      check("drain_head1", 32'(a_data), 32'h02);
      check("drain_level1", 32'(a_level), 1);
      step();
      check("drain_empty_valid", 32'(a_valid), 0);
      check("drain_level0", 32'(a_level), 0);
      step();
      check("drain_no_underflow", 32'(a_level), 0);
      a_ready = 0;
      send(8'h0F, 0);
      a_ready = 1;
      for (int i = 0; i < 8; i++) begin
         in_data = 8'(8'h10 + i);
         in_sel = 0;
         in_valid = 1;
         #1;
         check("pp_in_ready", 32'(in_ready), 1);
         check("pp_head", 32'(a_data), (i == 0) ? 32'h0F : 32'(8'h10 + i - 1));
         step();
         check("pp_level", 32'(a_level), 1);
      end
      in_valid = 0;
      check("pp_last", 32'(a_data), 32'h17);
      step();
      a_ready = 0;
      send(8'h31, 0);
      send(8'h32, 0);
      check("mid_a_level", 32'(a_level), 2);
      check("mid_b_level", 32'(b_level), 1);
      rst_n = 0;
      in_data = 8'h55;
      in_sel = 1;
      in_valid = 1;
      a_ready = 1;
      b_ready = 1;
      step();
      rst_n = 1;
      in_valid = 0;
      check("mid_levels", 32'({a_level, b_level}), 0);
      check("mid_valids", 32'({a_valid, b_valid}), 0);
      check("mid_data", 32'({a_data, b_data}), 0);
      step();
      check("mid_not_stored", 32'(b_valid), 0);
      for (int i = 0; i < 500; i++) begin
         logic ir;
         in_valid = 1'($urandom_range(0, 1));
         in_sel = 1'($urandom_range(0, 1));
         in_data = 8'($urandom);
         a_ready = 1'($urandom_range(0, 1));
         b_ready = 1'($urandom_range(0, 1));
         #1;
         ir = in_ready;
         a_ready = ~a_ready;
         b_ready = ~b_ready;
         #1;
         check("rnd_ready_indep", 32'(in_ready), 32'(ir));
         a_ready = ~a_ready;
         b_ready = ~b_ready;
         step();
      end
      in_valid = 0;
      a_ready = 1;
      b_ready = 1;
      step();
      step();
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
